// File: rtl/mem_if_unit.sv
// Cache-miss responder: serves I-cache line fills and D-cache line fills/write-backs
// as bursts from an on-chip word array. Optional macro: VCPU32_MEM_FAIR_ARB_EN.
module mem_if_unit #(
    parameter int WORD_LENGTH = 32,
    parameter int ADR_BITS    = 12,
    parameter int LINE_WORDS  = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ic_req,
    input  logic [ADR_BITS-1:0]           ic_adr,
    output logic                          ic_gnt,
    output logic                          ic_rvalid,
    output logic [WORD_LENGTH-1:0]        ic_rdata,
    output logic                          ic_done,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADR_BITS-1:0]           dc_adr,
    input  logic [WORD_LENGTH-1:0]        dc_wdata,
    output logic                          dc_gnt,
    output logic [$clog2(LINE_WORDS)-1:0] dc_idx,
    output logic                          dc_rvalid,
    output logic [WORD_LENGTH-1:0]        dc_rdata,
    output logic                          dc_done,
    output logic                          busy
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int LN_W  = ADR_BITS - IDX_W;
    localparam int DEPTH = 32'sd1 << ADR_BITS;
    localparam int LAT_W = (MEM_LATENCY > 32'sd1) ? $clog2(MEM_LATENCY) : 32'sd1;
    localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'((MEM_LATENCY > 32'sd0) ? MEM_LATENCY - 32'sd1 : 32'sd0);
    localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(32'sd1);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 32'sd1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(32'sd1);
    localparam logic             NO_WAIT   = (MEM_LATENCY == 32'sd0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   beat_r, beat_s;
    logic [LAT_W-1:0]   lat_cnt_r, lat_cnt_s;
    logic [LN_W-1:0]    line_r, line_s;
    logic               owner_dc_r, owner_dc_s;
    logic               we_r, we_s;
    logic               dc_wins_s, accept_ic_s, accept_dc_s;
    logic               rd_ic_s, rd_dc_s, xfer_dc_s;
    logic [ADR_BITS-1:0] rd_adr_s;
    logic [WORD_LENGTH-1:0] mem_r [0:DEPTH-1];
    logic               unused_s;

    assign unused_s = ^{ic_adr[IDX_W-1:0], dc_adr[IDX_W-1:0]};

`ifdef VCPU32_MEM_FAIR_ARB_EN
    logic [1:0] fair_cnt_r;

    // D-cache wins a tie once it has been passed over twice
    assign dc_wins_s = dc_req && (!ic_req || (fair_cnt_r == 2'd2));

    // Starvation counter: counts I grants taken while the D-cache was waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fair_cnt_r <= 2'd0;
        end else if (accept_dc_s) begin
            fair_cnt_r <= 2'd0;
        end else if (accept_ic_s && dc_req) begin
            fair_cnt_r <= fair_cnt_r + 2'd1;
        end else begin
            fair_cnt_r <= fair_cnt_r;
        end
    end
`else
    assign dc_wins_s = dc_req && !ic_req;
`endif

    assign accept_dc_s = (state_r == S_IDLE) && dc_wins_s;
    assign accept_ic_s = (state_r == S_IDLE) && ic_req && !dc_wins_s;

    // Next-state logic; acceptance latches the line, owner and direction
    always_comb begin
        state_s    = state_r;
        beat_s     = beat_r;
        lat_cnt_s  = lat_cnt_r;
        line_s     = line_r;
        owner_dc_s = owner_dc_r;
        we_s       = we_r;
        case (state_r)
            S_IDLE: begin
                if (accept_dc_s) begin
                    owner_dc_s = 1'b1;
                    we_s       = dc_we;
                    line_s     = dc_adr[ADR_BITS-1:IDX_W];
                end else begin
                    owner_dc_s = 1'b0;
                    we_s       = 1'b0;
                    line_s     = ic_adr[ADR_BITS-1:IDX_W];
                end
                beat_s    = '0;
                lat_cnt_s = LAT_LOAD;
                if (accept_dc_s || accept_ic_s) begin
                    state_s = (we_s || NO_WAIT) ? S_XFER : S_WAIT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (lat_cnt_r == '0) begin
                    state_s = S_XFER;
                end else begin
                    lat_cnt_s = lat_cnt_r - LAT_ONE;
                end
            end
            S_XFER: begin
                if (beat_r == LAST_BEAT) begin
                    state_s = S_DONE;
                end else begin
                    beat_s = beat_r + IDX_ONE;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so they line up with it
    assign xfer_dc_s = (state_s == S_XFER) && owner_dc_s;
    assign rd_ic_s   = (state_s == S_XFER) && !owner_dc_s && !we_s;
    assign rd_dc_s   = xfer_dc_s && !we_s;
    assign rd_adr_s  = {line_s, beat_s};

    // State and registered outputs; a reset abandons any burst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            beat_r     <= '0;
            lat_cnt_r  <= '0;
            line_r     <= '0;
            owner_dc_r <= 1'b0;
            we_r       <= 1'b0;
            ic_gnt     <= 1'b0;
            ic_rvalid  <= 1'b0;
            ic_rdata   <= '0;
            ic_done    <= 1'b0;
            dc_gnt     <= 1'b0;
            dc_idx     <= '0;
            dc_rvalid  <= 1'b0;
            dc_rdata   <= '0;
            dc_done    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            beat_r     <= beat_s;
            lat_cnt_r  <= lat_cnt_s;
            line_r     <= line_s;
            owner_dc_r <= owner_dc_s;
            we_r       <= we_s;
            ic_gnt     <= accept_ic_s;
            ic_rvalid  <= rd_ic_s;
            ic_rdata   <= rd_ic_s ? mem_r[rd_adr_s] : '0;
            ic_done    <= (state_s == S_DONE) && !owner_dc_s;
            dc_gnt     <= accept_dc_s;
            dc_idx     <= xfer_dc_s ? beat_s : '0;
            dc_rvalid  <= rd_dc_s;
            dc_rdata   <= rd_dc_s ? mem_r[rd_adr_s] : '0;
            dc_done    <= (state_s == S_DONE) && owner_dc_s;
            busy       <= (state_s != S_IDLE);
        end
    end

    // Write-back beat k lands at the edge that ends it; contents survive reset
    always_ff @(posedge clk) begin
        if ((state_r == S_XFER) && we_r) begin
            mem_r[{line_r, beat_r}] <= dc_wdata;
        end
    end
endmodule

// File: tb/tb_mem_if_unit.sv
// Scoreboard bench for mem_if_unit: random I/D traffic against a line-level memory
// model, plus directed reset, arbitration and zero-latency checks.
module tb_mem_if_unit;
    localparam int WL = 32;
    localparam int AB = 12;
    localparam int LW = 4;
    localparam int ML = 2;
    localparam int IW = 2;
`ifdef VCPU32_MEM_FAIR_ARB_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic          ic_req, ic_gnt, ic_rvalid, ic_done;
    logic [AB-1:0] ic_adr;
    logic [WL-1:0] ic_rdata;
    logic          dc_req, dc_we, dc_gnt, dc_rvalid, dc_done, busy;
    logic [AB-1:0] dc_adr;
    logic [WL-1:0] dc_wdata, dc_rdata;
    logic [IW-1:0] dc_idx;
    logic [WL-1:0] wbuf [LW];
    assign dc_wdata = wbuf[dc_idx];

    logic          ic_req0, ic_gnt0, ic_rvalid0, ic_done0;
    logic [AB-1:0] ic_adr0;
    logic [WL-1:0] ic_rdata0;
    logic          dc_req0, dc_we0, dc_gnt0, dc_rvalid0, dc_done0, busy0;
    logic [AB-1:0] dc_adr0;
    logic [WL-1:0] dc_wdata0, dc_rdata0;
    logic [IW-1:0] dc_idx0;
    assign dc_wdata0 = 32'h5000_0000 + 32'(dc_idx0);

    mem_if_unit #(.WORD_LENGTH(WL), .ADR_BITS(AB), .LINE_WORDS(LW), .MEM_LATENCY(ML)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_adr(ic_adr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
        .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_adr(dc_adr), .dc_wdata(dc_wdata),
        .dc_gnt(dc_gnt), .dc_idx(dc_idx), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
        .dc_done(dc_done), .busy(busy)
    );

    mem_if_unit #(.WORD_LENGTH(WL), .ADR_BITS(AB), .LINE_WORDS(LW), .MEM_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .ic_req(ic_req0), .ic_adr(ic_adr0), .ic_gnt(ic_gnt0), .ic_rvalid(ic_rvalid0),
        .ic_rdata(ic_rdata0), .ic_done(ic_done0),
        .dc_req(dc_req0), .dc_we(dc_we0), .dc_adr(dc_adr0), .dc_wdata(dc_wdata0),
        .dc_gnt(dc_gnt0), .dc_idx(dc_idx0), .dc_rvalid(dc_rvalid0), .dc_rdata(dc_rdata0),
        .dc_done(dc_done0), .busy(busy0)
    );

    int checks = 0;
    int failures = 0;
    logic [WL-1:0] mm [0:(1<<AB)-1];
    logic [WL-1:0] ic_exp[$];
    logic [WL-1:0] dc_exp[$];
    int grant_log[$];

    function automatic void chk(input string name, input logic [WL-1:0] act, input logic [WL-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void push_read(input bit to_dc, input logic [AB-1:0] adr);
        int b;
        b = (int'(adr) / LW) * LW;
        for (int k = 0; k < LW; k++) begin
            if (to_dc) dc_exp.push_back(mm[b + k]);
            else       ic_exp.push_back(mm[b + k]);
        end
    endfunction

    function automatic void model_write(input logic [AB-1:0] adr);
        int b;
        b = (int'(adr) / LW) * LW;
        for (int k = 0; k < LW; k++) mm[b + k] = wbuf[k];
    endfunction

    // Issue simultaneous requests; with no pending starvation the I-cache goes first
    task automatic issue(input bit do_i, input bit do_d, input logic [AB-1:0] ia,
                         input logic [AB-1:0] da, input bit dwe);
        @(negedge clk);
        if (do_i) push_read(1'b0, ia);
        if (do_d) begin
            if (dwe) model_write(da);
            else     push_read(1'b1, da);
        end
        ic_req = do_i; ic_adr = ia;
        dc_req = do_d; dc_we = dwe; dc_adr = da;
        for (int c = 0; c < 100 && (ic_req || dc_req); c++) begin
            @(negedge clk);
            if (ic_done) ic_req = 1'b0;
            if (dc_done) dc_req = 1'b0;
        end
        if (ic_req || dc_req) begin
            chk("issue_timeout", {30'd0, ic_req, dc_req}, '0);
            ic_req = 1'b0; dc_req = 1'b0;
        end
    endtask

    // Monitor: pops expected words and checks burst timing on every cycle
    int ic_cyc, ic_beats, dc_cyc, dc_beats;
    bit ic_in, dc_in, dc_wr, after_done;
    always @(negedge clk) begin
        if (!rst) begin
            ic_in = 1'b0; dc_in = 1'b0; after_done = 1'b0;
        end else begin
            if (after_done) chk("busy_after_done", busy, '0);
            after_done = ic_done || dc_done;
            chk("rvalid_exclusive", ic_rvalid & dc_rvalid, '0);
            if (ic_gnt) begin
                ic_in = 1'b1; ic_cyc = 0; ic_beats = 0; grant_log.push_back(0);
            end
            if (dc_gnt) begin
                dc_in = 1'b1; dc_cyc = 0; dc_beats = 0; dc_wr = dc_we; grant_log.push_back(1);
            end
            if (ic_rvalid) begin
                if (ic_beats == 0) chk("ic_first_beat_cycle", 32'(ic_cyc), 32'(ML));
                if (ic_exp.size() == 0) chk("ic_unexpected_rvalid", ic_rvalid, '0);
                else chk("ic_rdata", ic_rdata, ic_exp.pop_front());
                ic_beats++;
            end else begin
                chk("ic_rdata_idle_zero", ic_rdata, '0);
            end
            if (ic_done) begin
                chk("ic_burst_beats", 32'(ic_beats), 32'(LW));
                chk("ic_done_cycle", 32'(ic_cyc), 32'(ML + LW));
                ic_in = 1'b0;
            end
            if (ic_in) ic_cyc++;
            if (dc_in && dc_wr && !dc_done) chk("dc_idx_beat", 32'(dc_idx), 32'(dc_cyc));
            if (dc_rvalid) begin
                if (dc_beats == 0) chk("dc_first_beat_cycle", 32'(dc_cyc), 32'(ML));
                if (dc_exp.size() == 0) chk("dc_unexpected_rvalid", dc_rvalid, '0);
                else chk("dc_rdata", dc_rdata, dc_exp.pop_front());
                dc_beats++;
            end else begin
                chk("dc_rdata_idle_zero", dc_rdata, '0);
            end
            if (dc_done) begin
                if (dc_wr) begin
                    chk("dc_wr_done_cycle", 32'(dc_cyc), 32'(LW));
                end else begin
                    chk("dc_burst_beats", 32'(dc_beats), 32'(LW));
                    chk("dc_done_cycle", 32'(dc_cyc), 32'(ML + LW));
                end
                dc_in = 1'b0;
            end
            if (dc_in) dc_cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, start, c;
        logic [AB-1:0] ia, da;
        bit we;
        int exp_own [6];

        rst = 1'b0;
        ic_req = 1'b0; ic_adr = '0; dc_req = 1'b0; dc_we = 1'b0; dc_adr = '0;
        ic_req0 = 1'b0; ic_adr0 = '0; dc_req0 = 1'b0; dc_we0 = 1'b0; dc_adr0 = '0;
        for (int k = 0; k < LW; k++) wbuf[k] = '0;
        repeat (3) @(negedge clk);
        chk("reset_flags", {ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, busy, dc_idx}, '0);
        chk("reset_rdata", ic_rdata | dc_rdata, '0);
        rst = 1'b1;

        // Initialise lines 0..31 through write-backs
        for (int l = 0; l < 32; l++) begin
            for (int k = 0; k < LW; k++) wbuf[k] = $urandom;
            issue(1'b0, 1'b1, '0, AB'(l * LW), 1'b1);
        end

        // Line fill of 0x42 returns A0..A3 from line 0x40
        for (int k = 0; k < LW; k++) wbuf[k] = 32'hA0 + 32'(k);
        issue(1'b0, 1'b1, '0, 12'h040, 1'b1);
        issue(1'b1, 1'b0, 12'h042, '0, 1'b0);

        // Write-back at 0x10 then D fill at 0x13
        for (int k = 0; k < LW; k++) wbuf[k] = 32'hC0DE_0000 + 32'(k);
        issue(1'b0, 1'b1, '0, 12'h010, 1'b1);
        issue(1'b0, 1'b1, '0, 12'h013, 1'b0);

        // Simultaneous I and D requests, random traffic
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(2, 0);
            ia = AB'($urandom_range(127, 0));
            da = AB'($urandom_range(127, 0));
            we = 1'($urandom_range(1, 0));
            for (int k = 0; k < LW; k++) wbuf[k] = $urandom;
            issue(kind != 1, kind != 0, ia, da, we);
        end

        // Reset during beat 2 of a write-back keeps beats 0-1 only
        for (int k = 0; k < LW; k++) wbuf[k] = 32'hBEEF_0000 + 32'(k);
        @(negedge clk);
        dc_req = 1'b1; dc_we = 1'b1; dc_adr = 12'h010;
        for (c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (busy && dc_idx == 2'd2) break;
        end
        chk("rst_test_reached_beat2", {31'd0, busy && dc_idx == 2'd2}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid_flags", {ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, busy, dc_idx}, '0);
        chk("rst_mid_rdata", ic_rdata | dc_rdata, '0);
        mm[12'h010] = wbuf[0];
        mm[12'h011] = wbuf[1];
        @(negedge clk);
        dc_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        issue(1'b1, 1'b0, 12'h013, '0, 1'b0);

        // Both requests held: grant order shows the arbitration policy
        @(negedge clk);
        start = grant_log.size();
        for (int k = 0; k < 6; k++) begin
            exp_own[k] = (FAIR && (k % 3 == 2)) ? 1 : 0;
            push_read(exp_own[k] == 1, (exp_own[k] == 1) ? 12'h020 : 12'h044);
        end
        ic_req = 1'b1; ic_adr = 12'h044; dc_req = 1'b1; dc_we = 1'b0; dc_adr = 12'h020;
        for (c = 0; c < 300 && (grant_log.size() - start) < 6; c++) @(negedge clk);
        for (c = 0; c < 50 && !(ic_done || dc_done); c++) @(negedge clk);
        ic_req = 1'b0; dc_req = 1'b0;
        chk("arb_grant_count", 32'(grant_log.size() - start), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (start + k < grant_log.size())
                chk("arb_grant_order", 32'(grant_log[start + k]), 32'(exp_own[k]));
        end
        repeat (3) @(negedge clk);

        // Full readback of the initialised region
        for (int l = 0; l < 32; l++) issue(1'b1, 1'b0, AB'(l * LW), '0, 1'b0);
        repeat (3) @(negedge clk);
        chk("ic_exp_leftover", 32'(ic_exp.size()), '0);
        chk("dc_exp_leftover", 32'(dc_exp.size()), '0);

        // Zero-latency instance: first word arrives with the grant
        @(negedge clk);
        dc_req0 = 1'b1; dc_we0 = 1'b1; dc_adr0 = 12'h000;
        for (c = 0; c < 20 && !dc_done0; c++) @(negedge clk);
        chk("lat0_wr_done", dc_done0, 32'd1);
        dc_req0 = 1'b0;
        @(negedge clk);
        ic_req0 = 1'b1; ic_adr0 = 12'h001;
        for (c = 0; c < 20 && !ic_gnt0; c++) @(negedge clk);
        chk("lat0_gnt", ic_gnt0, 32'd1);
        for (int k = 0; k < LW; k++) begin
            chk("lat0_rvalid", ic_rvalid0, 32'd1);
            chk("lat0_rdata", ic_rdata0, 32'h5000_0000 + 32'(k));
            @(negedge clk);
        end
        chk("lat0_done", ic_done0, 32'd1);
        ic_req0 = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
